lbp: RTL and testbench

Local Binary Pattern engine for a 128×128 8-bit grayscale image. Reads pixels from an external gray-image memory over a request/address port and computes the 8-bit LBP code of every interior pixel. Writes each code to an external result memory at the same pixel address, then raises `finish`. Sits between the image source memory and the LBP result memory.

---
 rtl/lbp_pkg.sv | 28 ++
 rtl/lbp_compare.sv | 15 +
 rtl/lbp.sv | 195 +++++++++++++++++++
 tb/tb_lbp.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// Shared definitions for the Local Binary Pattern engine: default image
// geometry, FSM encoding and the neighbour-to-bit offset table.
package lbp_pkg;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WRITE = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Row/column delta of the neighbour that drives each code bit.
  localparam int NB_DR [8] = '{-1, -1, -1,  0,  0,  1,  1,  1};
  localparam int NB_DC [8] = '{-1,  0,  1, -1,  1, -1,  0,  1};

  // The 3x3 window is stored flat as row*3 + col, centre at slot 4.
  localparam int WIN_CENTER = 4;

  function automatic int win_idx(input int dr, input int dc);
    return (dr + 1) * 3 + (dc + 1);
  endfunction

endpackage

// File: rtl/lbp_compare.sv
// Combinational LBP code from a 3x3 window: bit i is set when the neighbour
// selected by the offset table is greater than or equal to the centre pixel.
module lbp_compare
  import lbp_pkg::*;
(
  input  logic [8:0][7:0] win,
  output logic [7:0]      code
);

  for (genvar i = 0; i < 8; i++) begin : g_bit
    localparam int NB_IDX = win_idx(NB_DR[i], NB_DC[i]);
    assign code[i] = (win[NB_IDX] >= win[WIN_CENTER]);
  end

endmodule

// File: rtl/lbp.sv
// LBP engine top: walks every interior centre in raster order, fills a 3x3
// window from the image memory (9 reads at row start, 3 per step after) and
// writes one code per centre to the result memory.
module lbp #(
  parameter int IMG_W = lbp_pkg::IMG_W,
  parameter int IMG_H = lbp_pkg::IMG_H,
  parameter int AW    = lbp_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [7:0]    gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  import lbp_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = AW - CW;
  localparam logic [RW-1:0] R_FIRST = RW'(1);
  localparam logic [RW-1:0] R_LAST  = RW'(IMG_H - 2);
  localparam logic [CW-1:0] C_FIRST = CW'(1);
  localparam logic [CW-1:0] C_LAST  = CW'(IMG_W - 2);

  state_e          state_r, state_nxt_s;
  logic [RW-1:0]   r_r, r_nxt_s;
  logic [CW-1:0]   c_r, c_nxt_s;
  logic [1:0]      frow_r, frow_nxt_s;
  logic [1:0]      fcol_r, fcol_nxt_s;
  logic [8:0][7:0] win_r, win_nxt_s;
  logic [3:0]      slot_s;
  logic [7:0]      code_s;
  logic            fetch_last_s, row_last_s, img_last_s;
  logic [RW-1:0]   fetch_row_s;
  logic [CW-1:0]   fetch_col_s;
  logic            gray_req_r, gray_req_nxt_s;
  logic [AW-1:0]   gray_addr_r, gray_addr_nxt_s;
  logic            lbp_valid_r, lbp_valid_nxt_s;
  logic [AW-1:0]   lbp_addr_r, lbp_addr_nxt_s;
  logic [7:0]      lbp_data_r, lbp_data_nxt_s;
  logic            finish_r, finish_nxt_s;

  assign slot_s       = ({2'b00, frow_r} * 4'd3) + {2'b00, fcol_r};
  assign fetch_last_s = (frow_r == 2'd2) && (fcol_r == 2'd2);
  assign row_last_s   = (c_r == C_LAST);
  assign img_last_s   = row_last_s && (r_r == R_LAST);

  // The code is taken from the window including the pixel arriving this cycle.
  lbp_compare u_compare (
    .win  (win_nxt_s),
    .code (code_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; leaving IDLE latches gray_ready for the whole run.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (gray_ready) state_nxt_s = ST_FETCH;
        else            state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (fetch_last_s) state_nxt_s = ST_WRITE;
        else              state_nxt_s = ST_FETCH;
      end
      ST_WRITE: begin
        if (img_last_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_NEXT;
      end
      ST_NEXT:  state_nxt_s = ST_FETCH;
      ST_DONE:  state_nxt_s = ST_DONE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath next values: window fill, counters, and registered ports.
  always_comb begin
    r_nxt_s         = r_r;
    c_nxt_s         = c_r;
    frow_nxt_s      = frow_r;
    fcol_nxt_s      = fcol_r;
    win_nxt_s       = win_r;
    lbp_valid_nxt_s = 1'b0;
    lbp_addr_nxt_s  = lbp_addr_r;
    lbp_data_nxt_s  = lbp_data_r;
    finish_nxt_s    = finish_r;
    case (state_r)
      ST_IDLE: begin
        frow_nxt_s = 2'd0;
        fcol_nxt_s = 2'd0;
      end
      ST_FETCH: begin
        win_nxt_s[slot_s] = gray_data;
        if (frow_r == 2'd2) begin
          frow_nxt_s = 2'd0;
          fcol_nxt_s = fcol_r + 2'd1;
        end else begin
          frow_nxt_s = frow_r + 2'd1;
        end
        if (fetch_last_s) begin
          lbp_valid_nxt_s = 1'b1;
          lbp_addr_nxt_s  = {r_r, c_r};
          lbp_data_nxt_s  = code_s;
        end else begin
          lbp_valid_nxt_s = 1'b0;
        end
      end
      ST_WRITE: begin
        if (img_last_s) finish_nxt_s = 1'b1;
        else            finish_nxt_s = finish_r;
      end
      ST_NEXT: begin
        frow_nxt_s = 2'd0;
        if (row_last_s) begin
          // New row: the whole window is refetched.
          r_nxt_s    = r_r + R_FIRST;
          c_nxt_s    = C_FIRST;
          fcol_nxt_s = 2'd0;
        end else begin
          c_nxt_s      = c_r + C_FIRST;
          fcol_nxt_s   = 2'd2;
          win_nxt_s[0] = win_r[1];
          win_nxt_s[1] = win_r[2];
          win_nxt_s[3] = win_r[4];
          win_nxt_s[4] = win_r[5];
          win_nxt_s[6] = win_r[7];
          win_nxt_s[7] = win_r[8];
        end
      end
      ST_DONE: begin
        finish_nxt_s = 1'b1;
      end
      default: begin
        finish_nxt_s = finish_r;
      end
    endcase

    gray_req_nxt_s = (state_nxt_s == ST_FETCH);
    fetch_row_s    = r_nxt_s + RW'(frow_nxt_s) - R_FIRST;
    fetch_col_s    = c_nxt_s + CW'(fcol_nxt_s) - C_FIRST;
    if (gray_req_nxt_s) gray_addr_nxt_s = {fetch_row_s, fetch_col_s};
    else                gray_addr_nxt_s = gray_addr_r;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_r         <= R_FIRST;
      c_r         <= C_FIRST;
      frow_r      <= 2'd0;
      fcol_r      <= 2'd0;
      win_r       <= '0;
      gray_req_r  <= 1'b0;
      gray_addr_r <= '0;
      lbp_valid_r <= 1'b0;
      lbp_addr_r  <= '0;
      lbp_data_r  <= 8'd0;
      finish_r    <= 1'b0;
    end else begin
      r_r         <= r_nxt_s;
      c_r         <= c_nxt_s;
      frow_r      <= frow_nxt_s;
      fcol_r      <= fcol_nxt_s;
      win_r       <= win_nxt_s;
      gray_req_r  <= gray_req_nxt_s;
      gray_addr_r <= gray_addr_nxt_s;
      lbp_valid_r <= lbp_valid_nxt_s;
      lbp_addr_r  <= lbp_addr_nxt_s;
      lbp_data_r  <= lbp_data_nxt_s;
      finish_r    <= finish_nxt_s;
    end
  end

  assign gray_req  = gray_req_r;
  assign gray_addr = gray_addr_r;
  assign lbp_valid = lbp_valid_r;
  assign lbp_addr  = lbp_addr_r;
  assign lbp_data  = lbp_data_r;
  assign finish    = finish_r;

endmodule

// File: tb/tb_lbp.sv
// Bench for the LBP engine on a 16x16 image: behavioural image/result
// memories, a table of probe points per directed image, and hand-written
// sequences for start gating, random images and reset mid-run.
module tb_lbp;

  localparam int W    = 16;
  localparam int H    = 16;
  localparam int AW   = 8;
  localparam int NPIX = W * H;
  localparam int NINT = (W - 2) * (H - 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  always #5 clk = ~clk;

  lbp #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  logic [7:0]    gray_mem [NPIX];
  logic [7:0]    res_mem  [NPIX];
  int            tests_run    = 0;
  int            tests_failed = 0;
  int            write_cnt, border_cnt, overlap_cnt, early_cnt, post_cnt;
  bit            ready_seen;
  bit            first_seen;
  logic [AW-1:0] first_addr;

  typedef struct {
    int         kind;
    int         row;
    int         col;
    logic [7:0] exp;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Tracks whether the engine has been allowed to start since reset.
  always @(posedge clk) begin
    if (!reset)          ready_seen = 1'b0;
    else if (gray_ready) ready_seen = 1'b1;
  end

  // Image memory (data after the falling edge) and result memory capture.
  always @(negedge clk) begin
    int row, col;
    if (gray_req) gray_data = gray_mem[gray_addr];
    else          gray_data = 8'hzz;
    if (gray_req && !ready_seen) early_cnt++;
    if (gray_req && !first_seen) begin
      first_seen = 1'b1;
      first_addr = gray_addr;
    end
    if (gray_req && lbp_valid) overlap_cnt++;
    if (finish && (gray_req || lbp_valid)) post_cnt++;
    if (lbp_valid) begin
      write_cnt++;
      row = int'(lbp_addr) / W;
      col = int'(lbp_addr) % W;
      if (row == 0 || row == H - 1 || col == 0 || col == W - 1) border_cnt++;
      res_mem[lbp_addr] = lbp_data;
    end
  end

  function automatic logic [7:0] pix(input int r, input int c);
    return gray_mem[r * W + c];
  endfunction

  function automatic logic [7:0] golden(input int r, input int c);
    int         nr [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    int         nc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    logic [7:0] code;
    code = 8'd0;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 8'd0;
    for (int b = 0; b < 8; b++) code[b] = (pix(r + nr[b], c + nc[b]) >= pix(r, c));
    return code;
  endfunction

  task automatic load_image(input int kind);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       gray_mem[i] = 8'd0;
        1:       gray_mem[i] = 8'(i % W);
        2:       gray_mem[i] = 8'd100;
        default: gray_mem[i] = (i % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 3));
      endcase
    end
    if (kind == 2) gray_mem[5 * W + 5] = 8'd200;
  endtask

  task automatic clear_stats();
    write_cnt = 0; border_cnt = 0; overlap_cnt = 0; early_cnt = 0; post_cnt = 0;
    first_seen = 1'b0;
    for (int i = 0; i < NPIX; i++) res_mem[i] = 8'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    gray_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    clear_stats();
  endtask

  task automatic start_and_wait(input int delay, input string tag);
    int cyc;
    repeat (delay) @(posedge clk);
    #1 gray_ready = 1'b1;
    @(posedge clk);
    #1 gray_ready = 1'b0;
    cyc = 0;
    while (finish !== 1'b1 && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({tag, "_finish"}, 32'(finish), 32'd1);
    check({tag, "_writes"}, 32'(write_cnt), 32'(NINT));
    check({tag, "_border_writes"}, 32'(border_cnt), 32'd0);
    check({tag, "_req_valid_overlap"}, 32'(overlap_cnt), 32'd0);
    check({tag, "_req_before_ready"}, 32'(early_cnt), 32'd0);
    check({tag, "_activity_after_finish"}, 32'(post_cnt), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic full_compare(input string tag);
    int mism = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (res_mem[r * W + c] !== golden(r, c)) mism++;
    check({tag, "_image_mismatches"}, 32'(mism), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gray_req"},  32'(gray_req),  32'd0);
    check({tag, "_gray_addr"}, 32'(gray_addr), 32'd0);
    check({tag, "_lbp_valid"}, 32'(lbp_valid), 32'd0);
    check({tag, "_lbp_addr"},  32'(lbp_addr),  32'd0);
    check({tag, "_lbp_data"},  32'(lbp_data),  32'd0);
    check({tag, "_finish"},    32'(finish),    32'd0);
  endtask

  initial begin
    int cur;
    // kind 0: all-zero image, kind 1: ramp gray = col, kind 2: spot at (5,5)
    vecs[0]  = '{0, 1, 1, 8'hFF};
    vecs[1]  = '{0, 7, 8, 8'hFF};
    vecs[2]  = '{0, 14, 14, 8'hFF};
    vecs[3]  = '{0, 0, 0, 8'h00};
    vecs[4]  = '{0, 15, 3, 8'h00};
    vecs[5]  = '{1, 1, 1, 8'hD6};
    vecs[6]  = '{1, 8, 14, 8'hD6};
    vecs[7]  = '{1, 14, 1, 8'hD6};
    vecs[8]  = '{1, 0, 5, 8'h00};
    vecs[9]  = '{1, 6, 15, 8'h00};
    vecs[10] = '{2, 5, 5, 8'h00};
    vecs[11] = '{2, 4, 4, 8'hFF};
    vecs[12] = '{2, 6, 6, 8'hFF};
    vecs[13] = '{2, 10, 10, 8'hFF};
    vecs[14] = '{2, 5, 4, 8'hFF};
    vecs[15] = '{2, 5, 0, 8'h00};

    reset = 1'b1;
    gray_ready = 1'b0;
    clear_stats();
    #2 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("reset");

    cur = -1;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].kind != cur) begin
        cur = vecs[i].kind;
        load_image(cur);
        apply_reset();
        if (cur == 0) begin
          start_and_wait(50, "zero");
          check("zero_first_gray_addr", 32'(first_addr), 32'd0);
        end else begin
          start_and_wait(0, $sformatf("kind%0d", cur));
        end
      end
      check($sformatf("vec%0d_r%0d_c%0d", i, vecs[i].row, vecs[i].col),
            32'(res_mem[vecs[i].row * W + vecs[i].col]), 32'(vecs[i].exp));
    end

    load_image(3);
    apply_reset();
    start_and_wait(3, "rand");
    full_compare("rand");

    // Reset in the middle of a run, then a complete rerun.
    load_image(3);
    apply_reset();
    #1 gray_ready = 1'b1;
    @(posedge clk);
    #1 gray_ready = 1'b0;
    repeat (300) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("midreset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_stats();
    start_and_wait(2, "rerun");
    full_compare("rerun");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
